// File: rtl/coproc_seq_pkg.sv
// Shared definitions for the coprocessor command sequencer: register map,
// CTRL/STATUS bit positions and the sequencer FSM state encoding.
package coproc_seq_pkg;

  localparam int unsigned OPW_DEF = 3;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_TLIMIT = 2'd2;
  localparam logic [1:0] ADDR_CCOUNT = 2'd3;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_OP_LSB = 1;
  localparam int unsigned CTRL_IRQ_EN = 8;

  localparam int unsigned ST_BUSY     = 0;
  localparam int unsigned ST_DONE     = 1;
  localparam int unsigned ST_TIMEOUT  = 2;
  localparam int unsigned ST_ERR_BUSY = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_WAIT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/coproc_seq_fsm.sv
// Launch/complete/timeout sequencing for one coprocessor operation; drives
// the cp_* handshake and reports accept/done/timeout events to the register file.
module coproc_seq_fsm
  import coproc_seq_pkg::*;
#(
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start_req,
  input  logic [OPW-1:0] opcode_in,
  input  logic [31:0]    timeout_limit,
  input  logic           cp_done,
  output logic           cp_start,
  output logic [OPW-1:0] cp_opcode,
  output logic           cp_abort,
  output logic           busy,
  output logic           accept,
  output logic           done_pulse,
  output logic           timeout_pulse,
  output logic [31:0]    op_cycles
);

  seq_state_e  state, state_next;
  logic [31:0] tcnt;
  logic [31:0] wcnt;
  logic [31:0] cnt_spent;
  logic        tmo_hit;
  logic        launch;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    launch        = 1'b0;
    done_pulse    = 1'b0;
    timeout_pulse = 1'b0;
    // cycles spent in ARM+WAIT, counting the current one
    cnt_spent     = tcnt + 32'd1;
    tmo_hit       = (timeout_limit != '0) && (cnt_spent == timeout_limit);
    op_cycles     = (wcnt == '1) ? '1 : wcnt + 32'd1;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          accept     = 1'b1;
          state_next = S_ARM;
        end
      end
      S_ARM: begin
        if (tmo_hit) begin
          timeout_pulse = 1'b1;
          state_next    = S_IDLE;
        end else if (!cp_done) begin
          launch     = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cp_done) begin
          done_pulse = 1'b1;
          state_next = S_IDLE;
        end else if (tmo_hit) begin
          timeout_pulse = 1'b1;
          state_next    = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt      <= '0;
      wcnt      <= '0;
      cp_start  <= 1'b0;
      cp_abort  <= 1'b0;
      cp_opcode <= '0;
    end else begin
      cp_start <= launch;
      cp_abort <= timeout_pulse;
      if (accept) begin
        tcnt      <= '0;
        cp_opcode <= opcode_in;
      end else if (busy) begin
        tcnt <= cnt_spent;
      end
      if (launch)               wcnt <= '0;
      else if (state == S_WAIT) wcnt <= op_cycles;
    end
  end

endmodule

// File: rtl/coproc_cmd_sequencer.sv
// Avalon-MM register front end for the coprocessor sequencer: CTRL, sticky
// STATUS, TIMEOUT_LIMIT, CYCLE_COUNT, registered read mux and level irq.
module coproc_cmd_sequencer
  import coproc_seq_pkg::*;
#(
  parameter int unsigned OPW         = OPW_DEF,
  parameter logic [31:0] TIMEOUT_RST = 32'd1_000_000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [1:0]     address,
  input  logic           write,
  input  logic [31:0]    writedata,
  output logic [31:0]    readdata,
  output logic           cp_start,
  output logic [OPW-1:0] cp_opcode,
  output logic           cp_abort,
  input  logic           cp_done,
  output logic           irq
);

  logic           ctrl_wr, status_wr, tlimit_wr, start_req;
  logic           busy, accept, done_pulse, timeout_pulse;
  logic [31:0]    op_cycles;
  logic [OPW-1:0] opcode;
  logic           irq_en;
  logic           st_done, st_timeout, st_err_busy;
  logic [31:0]    timeout_limit;
  logic [31:0]    cycle_count;
  logic [31:0]    rd_mux;

  assign ctrl_wr   = write && (address == ADDR_CTRL);
  assign status_wr = write && (address == ADDR_STATUS);
  assign tlimit_wr = write && (address == ADDR_TLIMIT);
  assign start_req = ctrl_wr && writedata[CTRL_START];

  coproc_seq_fsm #(.OPW(OPW)) u_fsm (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_req     (start_req),
    .opcode_in     (writedata[CTRL_OP_LSB +: OPW]),
    .timeout_limit (timeout_limit),
    .cp_done       (cp_done),
    .cp_start      (cp_start),
    .cp_opcode     (cp_opcode),
    .cp_abort      (cp_abort),
    .busy          (busy),
    .accept        (accept),
    .done_pulse    (done_pulse),
    .timeout_pulse (timeout_pulse),
    .op_cycles     (op_cycles)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL: begin
        rd_mux[CTRL_IRQ_EN]          = irq_en;
        rd_mux[CTRL_OP_LSB +: OPW]   = opcode;
      end
      ADDR_STATUS: begin
        rd_mux[ST_BUSY]     = busy;
        rd_mux[ST_DONE]     = st_done;
        rd_mux[ST_TIMEOUT]  = st_timeout;
        rd_mux[ST_ERR_BUSY] = st_err_busy;
      end
      ADDR_TLIMIT: rd_mux = timeout_limit;
      default:     rd_mux = cycle_count;
    endcase
  end

  // Sticky bits: a set event in the same cycle overrides a write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opcode        <= '0;
      irq_en        <= 1'b0;
      st_done       <= 1'b0;
      st_timeout    <= 1'b0;
      st_err_busy   <= 1'b0;
      timeout_limit <= TIMEOUT_RST;
      cycle_count   <= '0;
      irq           <= 1'b0;
      readdata      <= '0;
    end else begin
      readdata <= rd_mux;
      irq      <= irq_en & (st_done | st_timeout);
      if (ctrl_wr) begin
        irq_en <= writedata[CTRL_IRQ_EN];
        if (!busy) opcode <= writedata[CTRL_OP_LSB +: OPW];
      end
      if (tlimit_wr)  timeout_limit <= writedata;
      if (done_pulse) cycle_count   <= op_cycles;
      st_done     <= done_pulse    | (st_done     & ~(status_wr & writedata[ST_DONE]));
      st_timeout  <= timeout_pulse | (st_timeout  & ~(status_wr & writedata[ST_TIMEOUT]));
      st_err_busy <= (start_req & busy & ~accept)
                   | (st_err_busy & ~(status_wr & writedata[ST_ERR_BUSY]));
    end
  end

endmodule

// File: tb/tb_coproc_cmd_sequencer.sv
// Directed self-checking bench for coproc_cmd_sequencer.
module tb_coproc_cmd_sequencer;

  localparam logic [31:0] TRST = 32'd5000;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        cp_start;
  logic [2:0]  cp_opcode;
  logic        cp_abort;
  logic        cp_done;
  logic        irq;

  int unsigned total = 0;
  int unsigned bad   = 0;

  coproc_cmd_sequencer #(.OPW(3), .TIMEOUT_RST(TRST)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .cp_start  (cp_start),
    .cp_opcode (cp_opcode),
    .cp_abort  (cp_abort),
    .cp_done   (cp_done),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
    writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  initial begin
    logic [31:0] d;
    int unsigned n;
    int unsigned starts;
    int unsigned aborts;

    reset_n   = 1'b0;
    address   = 2'd0;
    write     = 1'b0;
    writedata = '0;
    cp_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_outputs", {29'b0, cp_start, cp_abort, irq}, 32'h0);
    chk("rst_opcode", {29'b0, cp_opcode}, 32'h0);
    reset_n = 1'b1;
    rd(2'd2, d);
    chk("rst_tlimit", d, TRST);

    // basic op: START, opcode 2, IRQ_EN; done 10 cycles after cp_start
    wr(2'd0, 32'h105);
    n = 0;
    while (!cp_start && n < 20) begin
      tick();
      n++;
    end
    chk("basic_start_latency", n, 32'd1);
    chk("basic_opcode", {29'b0, cp_opcode}, 32'd2);
    starts = 0;
    repeat (10) begin
      tick();
      if (cp_start) starts++;
    end
    cp_done = 1'b1;
    tick();
    cp_done = 1'b0;
    rd(2'd3, d);
    chk("basic_cycle_count", d, 32'd11);
    rd(2'd1, d);
    chk("basic_status", d, 32'h2);
    chk("basic_irq", {31'b0, irq}, 32'd1);
    chk("basic_single_start", starts, 32'd0);
    rd(2'd0, d);
    chk("basic_ctrl_read", d, 32'h104);

    // irq clear
    wr(2'd1, 32'h2);
    tick();
    chk("irqclr_irq", {31'b0, irq}, 32'd0);
    rd(2'd1, d);
    chk("irqclr_status", d, 32'h0);

    // stale done held across START
    cp_done = 1'b1;
    wr(2'd0, 32'h107);
    address = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stale_hold", {30'b0, cp_start, readdata[0]}, 32'h1);
    end
    cp_done = 1'b0;
    tick();
    chk("stale_start", {31'b0, cp_start}, 32'd1);
    cp_done = 1'b1;
    tick();
    cp_done = 1'b0;
    rd(2'd3, d);
    chk("stale_min_count", d, 32'd1);

    // timeout
    wr(2'd1, 32'hE);
    wr(2'd2, 32'd20);
    wr(2'd0, 32'h101);
    aborts = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (cp_abort) aborts++;
    end
    chk("tmo_early_abort", aborts, 32'd0);
    tick();
    chk("tmo_abort_edge", {31'b0, cp_abort}, 32'd1);
    repeat (5) begin
      tick();
      if (cp_abort) aborts++;
    end
    chk("tmo_single_abort", aborts, 32'd0);
    rd(2'd1, d);
    chk("tmo_status", d, 32'h4);
    rd(2'd3, d);
    chk("tmo_count_kept", d, 32'd1);
    chk("tmo_irq", {31'b0, irq}, 32'd1);

    // busy collision, timeout disabled
    wr(2'd1, 32'hF);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h3);
    starts = 0;
    repeat (3) begin
      if (cp_start) starts++;
      tick();
    end
    wr(2'd0, 32'hB);
    repeat (3) begin
      if (cp_start) starts++;
      tick();
    end
    chk("coll_single_start", starts, 32'd1);
    chk("coll_opcode", {29'b0, cp_opcode}, 32'd1);
    rd(2'd1, d);
    chk("coll_status", d, 32'h9);
    rd(2'd0, d);
    chk("coll_ctrl_read", d, 32'h2);

    // reset in WAIT
    rd(2'd3, d);
    chk("mid_pre_readdata", d, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_readdata", readdata, 32'h0);
    chk("mid_outputs", {29'b0, cp_start, cp_abort, irq}, 32'h0);
    chk("mid_opcode", {29'b0, cp_opcode}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd(2'd2, d);
    chk("mid_tlimit", d, TRST);
    rd(2'd1, d);
    chk("mid_status", d, 32'h0);
    aborts = 0;
    repeat (3) begin
      tick();
      if (cp_abort) aborts++;
    end
    chk("mid_no_abort", aborts, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
